// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data memory / MMIO block: register addresses,
// STATUS bit layout and the address-decode select type.
package data_mem_mmio_pkg;

  localparam logic [31:0] ADDR_LED    = 32'h0000_1000;
  localparam logic [31:0] ADDR_CYCLES = 32'h0000_1004;
  localparam logic [31:0] ADDR_TXDATA = 32'h0000_1008;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_100C;

  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_COUNT_LSB = 3;
  localparam int unsigned STAT_COUNT_W   = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_CYCLES,
    SEL_TXDATA,
    SEL_STATUS
  } sel_e;

endpackage

// File: rtl/data_mem_mmio_if.sv
// Memory-stage bus plus transmit byte stream between the core and data_mem_mmio.
interface data_mem_mmio_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output we, a, wd, tx_ready, input rd, led, tx_data, tx_valid);
  modport slave  (input we, a, wd, tx_ready, output rd, led, tx_data, tx_valid);
endinterface

// File: rtl/data_mem_mmio_tx_fifo.sv
// Byte FIFO feeding the transmit stream; power-of-two depth, wrapping pointers,
// registered full/empty/count, head forced to zero while empty.
module tx_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head_c,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_c = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/data_mem_mmio.sv
// Word-addressed data RAM with LED, cycle counter, transmit queue and status
// registers mapped above it; loads are combinational from the address.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned TXQ_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  data_mem_mmio_if.slave bus
);

  localparam int unsigned IW = $clog2(RAM_WORDS);
  localparam int unsigned CW = $clog2(TXQ_DEPTH + 1);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   addr_w;
  logic [31:0]   cycles;
  logic [31:0]   status;
  logic [31:0]   rd_c;
  logic [7:0]    led_reg;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  sel_e          sel;

  // Byte offset within the word never affects decode.
  assign addr_w = bus.a & 32'hFFFF_FFFC;

  always_comb begin
    sel = SEL_NONE;
    if (addr_w < 32'(RAM_WORDS * 4)) begin
      sel = SEL_RAM;
    end else begin
      case (addr_w)
        ADDR_LED:    sel = SEL_LED;
        ADDR_CYCLES: sel = SEL_CYCLES;
        ADDR_TXDATA: sel = SEL_TXDATA;
        ADDR_STATUS: sel = SEL_STATUS;
        default:     sel = SEL_NONE;
      endcase
    end
  end

  assign push = bus.we && (sel == SEL_TXDATA);
  assign pop  = !empty && bus.tx_ready;

  tx_fifo #(.DEPTH(TXQ_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.wd[7:0]),
    .pop       (pop),
    .head_c    (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (bus.we && (sel == SEL_RAM)) ram[bus.a[IW+1:2]] <= bus.wd;
  end

  // Overflow clear wins over a set, though both cannot come from one access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_reg  <= 8'h00;
      cycles   <= 32'h0;
      overflow <= 1'b0;
    end else begin
      cycles <= cycles + 32'd1;
      if (bus.we && (sel == SEL_LED)) led_reg <= bus.wd[7:0];
      if (bus.we && (sel == SEL_STATUS)) begin
        overflow <= 1'b0;
      end else if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    status                                   = '0;
    status[STAT_FULL_BIT]                    = full;
    status[STAT_EMPTY_BIT]                   = empty;
    status[STAT_OVF_BIT]                     = overflow;
    status[STAT_COUNT_LSB +: STAT_COUNT_W]   = 4'(count);
  end

  always_comb begin
    rd_c = 32'h0;
    case (sel)
      SEL_RAM:    rd_c = ram[bus.a[IW+1:2]];
      SEL_LED:    rd_c = {24'h0, led_reg};
      SEL_CYCLES: rd_c = cycles;
      SEL_STATUS: rd_c = status;
      default:    rd_c = 32'h0;
    endcase
  end

  assign bus.rd       = rd_c;
  assign bus.led      = led_reg;
  assign bus.tx_data  = head;
  assign bus.tx_valid = !empty;

endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 Parameter RAM_WORDS, default 64, number of 32-bit data RAM words (power of two).
REQ-002 Parameter TXQ_DEPTH, default 4, transmit queue entries (power of two).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 we  input  1  store strobe from the memory stage (MemWriteM).
REQ-006 a  input  32  byte address from the memory stage (ALUOutM).
REQ-007 wd  input  32  store data (WriteDataM).
REQ-008 rd  output  32  load data (ReadDataM), combinational from a.
REQ-009 led  output  8  LED register contents.
REQ-010 tx_data  output  8  head of the transmit queue.
REQ-011 tx_valid  output  1  transmit queue non-empty.
REQ-012 tx_ready  input  1  consumer accepts tx_data when tx_valid && tx_ready at a rising edge.

Function
REQ-013 Address bits a[1:0] SHALL be ignored; all accesses are word accesses.
REQ-014 RAM region: a < RAM_WORDS*4; index a[log2(RAM_WORDS)+1:2]; read combinational; write on rising edge when we=1.
REQ-015 A same-cycle read and write to one RAM word SHALL return the old contents on rd.
REQ-016 MMIO 0x0000_1000 LED: read {24'b0, led}; write loads wd[7:0].
REQ-017 MMIO 0x0000_1004 CYCLES: read-only 32-bit counter, +1 every cycle after reset, wraps 0xFFFF_FFFF -> 0; writes ignored.
REQ-018 MMIO 0x0000_1008 TXDATA: write with queue not full pushes wd[7:0]; read returns 0.
REQ-019 MMIO 0x0000_100C STATUS: read {25'b0, count[3:0] (bits 6:3), overflow (bit 2), empty (bit 1), full (bit 0)}; any write clears overflow.
REQ-020 Write to TXDATA with queue full SHALL be dropped and set sticky overflow.
REQ-021 Pop SHALL occur when tx_valid && tx_ready; queue is FIFO-ordered with wrapping read/write pointers.
REQ-022 Simultaneous push and pop SHALL both take effect, count unchanged; when full, a simultaneous pop makes room and the push is accepted without overflow.
REQ-023 When the overflow set (REQ-020) and the clear (REQ-019) would occur together they cannot coincide (different addresses); clear has priority if both are ever asserted.
REQ-024 Any other address SHALL read 0 and ignore writes.
REQ-025 tx_data SHALL be stable while tx_valid=1 and tx_ready=0.

Reset
REQ-026 On reset low: led=0, CYCLES=0, queue empty (tx_valid=0, count=0), overflow=0, tx_data=0.
REQ-027 RAM contents are not reset.
REQ-028 Reset asserted mid-transfer SHALL discard all queued bytes immediately, without waiting for a clock edge.
REQ-029 First CYCLES increment occurs on the first rising edge after reset deasserts.

Structure
REQ-030 Shared package holds MMIO address constants (LED, CYCLES, TXDATA, STATUS) and STATUS bit positions.
REQ-031 Transmit queue SHALL be a sub-module tx_fifo (parameterised depth, push/pop/full/empty/count).
REQ-032 Address decode and read mux SHALL be combinational in data_mem_mmio; no extra load latency.

Verification
REQ-033 Write 0xDEADBEEF to 0x10, read 0x10 -> 0xDEADBEEF; read 0x13 -> 0xDEADBEEF.
REQ-034 Write 0x1A5 to 0x1000 -> led=0xA5, read 0x1000 -> 0x000000A5.
REQ-035 tx_ready=0; five writes 0x41..0x45 to 0x1008 -> STATUS read = 0x25 (count 4, overflow, full); tx_data=0x41.
REQ-036 Then tx_ready=1 for 4 cycles -> tx_data sequence 0x41,0x42,0x43,0x44, then tx_valid=0; write STATUS -> STATUS read = 0x02.
REQ-037 Queue full, tx_ready=1 and push 0x55 in the same cycle -> no overflow, count stays 4, 0x55 emerges last.
REQ-038 Read CYCLES 10 cycles apart -> difference 10; assert reset mid-run -> CYCLES=0, tx_valid=0 before next edge.
